// File: rtl/regs_debug_dump.sv
// Debug-side register dump: walks the heap's debugger read port and streams every
// word as a framed byte sequence (header, data MSB-first, XOR checksum) over valid/ready.
module regs_debug_dump #(
    parameter int         NUM_REGS = 32,
    parameter int         ADDR_W   = 5,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] dbg_addr_o,
    input  logic [31:0]       dbg_val_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i
);

    typedef enum logic [2:0] {IDLE, HDR, LOAD, SEND, CSUM, FIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              txValid_q;
    logic              abortPend_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        txData_q;
    logic [7:0]        checksum_q;
    logic [23:0]       shiftReg_q;
    logic [1:0]        byteCnt_q;

    logic              xfer;
    logic              abortReq;
    logic [7:0]        checksum_d;
    logic [23:0]       shiftReg_d;

    // shiftReg_q holds only the bytes still queued behind the one on tx_data_o.
    assign xfer       = txValid_q && tx_ready_i;
    assign abortReq   = abort_i || abortPend_q;
    assign checksum_d = checksum_q ^ txData_q;
    assign shiftReg_d = {shiftReg_q[15:0], 8'h00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            txValid_q   <= 1'b0;
            abortPend_q <= 1'b0;
            addr_q      <= '0;
            txData_q    <= 8'h00;
            checksum_q  <= 8'h00;
            shiftReg_q  <= '0;
            byteCnt_q   <= 2'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    abortPend_q <= 1'b0;
                    if (start_i) begin
                        state_q    <= HDR;
                        busy_q     <= 1'b1;
                        addr_q     <= '0;
                        checksum_q <= 8'h00;
                        txData_q   <= HDR_BYTE;
                        txValid_q  <= 1'b1;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        txValid_q <= 1'b0;
                        if (abortReq) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= LOAD;
                        end
                    end else if (abort_i) begin
                        abortPend_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        shiftReg_q <= dbg_val_i[23:0];
                        txData_q   <= dbg_val_i[31:24];
                        txValid_q  <= 1'b1;
                        byteCnt_q  <= 2'd0;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        checksum_q <= checksum_d;
                        shiftReg_q <= shiftReg_d;
                        byteCnt_q  <= byteCnt_q + 2'd1;
                        if (abortReq) begin
                            txValid_q <= 1'b0;
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                        end else if (byteCnt_q == 2'd3) begin
                            if (addr_q == LAST_ADDR) begin
                                txData_q <= checksum_d;
                                state_q  <= CSUM;
                            end else begin
                                addr_q    <= addr_q + ADDR_W'(1);
                                txValid_q <= 1'b0;
                                state_q   <= LOAD;
                            end
                        end else begin
                            txData_q <= shiftReg_q[23:16];
                        end
                    end else if (abort_i) begin
                        abortPend_q <= 1'b1;
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        txValid_q <= 1'b0;
                        if (abortReq) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end else if (abort_i) begin
                        abortPend_q <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    txValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign dbg_addr_o = addr_q;
    assign tx_data_o  = txData_q;
    assign tx_valid_o = txValid_q;

endmodule
